// File: rtl/csoc_scan_mchain.sv
// csoc_scan_mchain: multi-chain scan/test IO frame emulator for the CSOC pad ring.
// Shift, capture (chain inversion) and functional pad loopback, all registered.
module csoc_scan_mchain #(
  parameter int NCHAINS   = 4,
  parameter int CHAIN_LEN = 480
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       test_tm_i,
  input  logic       test_se_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  input  logic       uart_read_i,
  output logic       uart_write_o,
  input  logic       xtal_a_i,
  output logic       xtal_b_o,
  output logic       clk_o
);
  localparam int CNT_W = $clog2(CHAIN_LEN);

  if (NCHAINS < 1 || NCHAINS > 7) begin : g_bad_nchains
    $error("csoc_scan_mchain: NCHAINS must be 1..7");
  end
  if (CHAIN_LEN < 2) begin : g_bad_len
    $error("csoc_scan_mchain: CHAIN_LEN must be >= 2");
  end

  logic [CHAIN_LEN-1:0] chain_q [NCHAINS];
  logic [CHAIN_LEN-1:0] chain_d [NCHAINS];
  logic [CNT_W-1:0]     shift_cnt_q, shift_cnt_d;
  logic [7:0]           data_q, data_d;
  logic                 uart_q, uart_d;
  logic                 shift_en, cap_en, cnt_wrap;

  always_comb begin
    shift_en    = test_tm_i & test_se_i;
    cap_en      = test_tm_i & ~test_se_i;
    cnt_wrap    = shift_cnt_q == CNT_W'(CHAIN_LEN - 1);
    shift_cnt_d = (shift_en && !cnt_wrap) ? shift_cnt_q + 1'b1 : '0;
    uart_d      = ~test_tm_i & uart_read_i;
    // data_o[7] is the load-complete flag; unused chain lanes read back as 0
    data_d      = !test_tm_i ? data_i : shift_en ? {cnt_wrap, 7'b0} : {1'b0, data_q[6:0]};
    for (int k = 0; k < NCHAINS; k++) begin
      chain_d[k] = shift_en ? {data_i[k], chain_q[k][CHAIN_LEN-1:1]} :
                   cap_en   ? ~chain_q[k] : chain_q[k];
      if (shift_en) data_d[k] = chain_q[k][0];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < NCHAINS; k++) chain_q[k] <= '0;
      shift_cnt_q <= '0;
      data_q      <= 8'h00;
      uart_q      <= 1'b0;
    end else begin
      for (int k = 0; k < NCHAINS; k++) chain_q[k] <= chain_d[k];
      shift_cnt_q <= shift_cnt_d;
      data_q      <= data_d;
      uart_q      <= uart_d;
    end
  end

  assign data_o       = data_q;
  assign uart_write_o = uart_q;
  assign xtal_b_o     = ~xtal_a_i;
  assign clk_o        = xtal_a_i;
endmodule

// File: tb/tb_csoc_scan_mchain.sv
// tb_csoc_scan_mchain: directed checks of csoc_scan_mchain with 4 chains of 8 flops.
module tb_csoc_scan_mchain;
  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic       test_tm_i = 1'b0;
  logic       test_se_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic [7:0] data_o;
  logic       uart_read_i = 1'b0;
  logic       uart_write_o;
  logic       xtal_a_i = 1'b0;
  logic       xtal_b_o;
  logic       clk_o;

  int n_checks = 0;
  int n_fail   = 0;

  csoc_scan_mchain #(.NCHAINS(4), .CHAIN_LEN(8)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .test_tm_i(test_tm_i), .test_se_i(test_se_i),
    .data_i(data_i), .data_o(data_o), .uart_read_i(uart_read_i), .uart_write_o(uart_write_o),
    .xtal_a_i(xtal_a_i), .xtal_b_o(xtal_b_o), .clk_o(clk_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    #3;
    rstn_i = 1'b1;
  endtask

  // upper (unused) data_i bits are randomised to show they are ignored in test mode
  task automatic shift_edge(input logic [3:0] lanes);
    test_tm_i = 1'b1;
    test_se_i = 1'b1;
    data_i    = {4'($urandom), lanes};
    step();
  endtask

  task automatic load(input logic [7:0] v);
    for (int j = 0; j < 8; j++) shift_edge({4{v[j]}});
  endtask

  task automatic unload_chk(input string tag, input logic [7:0] exp);
    logic [7:0] r [4];
    for (int j = 0; j < 8; j++) begin
      shift_edge(4'h0);
      for (int k = 0; k < 4; k++) r[k][j] = data_o[k];
    end
    for (int k = 0; k < 4; k++) chk(tag, r[k], exp);
  endtask

  initial begin
    logic [7:0] pat [4];
    logic [7:0] exp;
    logic [7:0] r;
    for (int k = 0; k < 4; k++) pat[k] = 8'hA5 ^ 8'(k);

    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      test_tm_i = 1'($urandom); test_se_i = 1'($urandom); data_i = 8'($urandom);
      uart_read_i = 1'($urandom); xtal_a_i = 1'($urandom);
      step();
      chk("rst_data", data_o, 8'h00);
      chk("rst_uart", {7'b0, uart_write_o}, 8'h00);
      chk("rst_xtal_b", {7'b0, xtal_b_o}, {7'b0, ~xtal_a_i});
      chk("rst_clk_o", {7'b0, clk_o}, {7'b0, xtal_a_i});
    end
    uart_read_i = 1'b0;
    do_reset();

    // 16-edge shift of per-chain pattern, LSB first
    for (int e = 1; e <= 16; e++) begin
      logic [3:0] l;
      for (int k = 0; k < 4; k++) l[k] = pat[k][(e - 1) % 8];
      shift_edge(l);
      exp = 8'h00;
      if (e > 8) for (int k = 0; k < 4; k++) exp[k] = pat[k][e - 9];
      exp[7] = (e == 8 || e == 16);
      chk("shift", data_o, exp);
    end

    // capture inverts loaded 3C to C3
    do_reset();
    load(8'h3C);
    chk("cap_pre_flag", data_o, 8'h80);
    test_se_i = 1'b0;
    step();
    chk("cap_flag_clr", data_o, 8'h00);
    unload_chk("capture", 8'hC3);

    // abort: 5 shift edges of ones, one capture edge, resume
    do_reset();
    for (int j = 0; j < 5; j++) shift_edge(4'hF);
    test_se_i = 1'b0;
    step();
    r = 8'h00;
    for (int j = 0; j < 8; j++) begin
      shift_edge(4'h0);
      r[j] = data_o[0];
      chk("abort_flag", {7'b0, data_o[7]}, {7'b0, j == 7});
    end
    chk("abort_chain", r, 8'h07);

    // functional loopback; se high is ignored when tm is low
    do_reset();
    load(8'h96);
    test_tm_i = 1'b0; test_se_i = 1'b1; data_i = 8'h5A; uart_read_i = 1'b1;
    step();
    chk("func_data", data_o, 8'h5A);
    chk("func_uart", {7'b0, uart_write_o}, 8'h01);
    data_i = 8'hC3; uart_read_i = 1'b0;
    step();
    chk("func_data2", data_o, 8'hC3);
    chk("func_uart2", {7'b0, uart_write_o}, 8'h00);
    uart_read_i = 1'b1;
    unload_chk("func_hold", 8'h96);
    chk("test_uart_off", {7'b0, uart_write_o}, 8'h00);
    uart_read_i = 1'b0;

    // reset asserted mid-shift
    do_reset();
    load(8'hFF);
    for (int j = 0; j < 4; j++) shift_edge(4'h0);
    chk("mid_pre", data_o, 8'h0F);
    rstn_i = 1'b0;
    #2;
    chk("mid_rst", data_o, 8'h00);
    #2;
    rstn_i = 1'b1;
    for (int j = 0; j < 8; j++) begin
      shift_edge(4'hF);
      chk("rst_reload", data_o, (j == 7) ? 8'h80 : 8'h00);
    end
    unload_chk("rst_readout", 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
